// File: rtl/atm_pin_controller.sv
// ATM access controller: card detect, strobed PIN entry checked against a parameter code,
// dispense/destroy/wrong pulses and status outputs for the LED/7-segment front panel.
module atm_pin_controller #(
  parameter int unsigned DIGIT_W        = 3,
  parameter int unsigned CODE_LEN       = 3,
  parameter logic [DIGIT_W*CODE_LEN-1:0] CODE = 9'h05F,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned TryW = $clog2(MAX_TRIES + 1),
  localparam int unsigned CntW = $clog2(CODE_LEN + 1)
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic               card,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               dispense,
  output logic               destroy,
  output logic               wrong,
  output logic [TryW-1:0]    tries_left,
  output logic [CntW-1:0]    digits_entered,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StEntry      = 3'd1,
    StCheck      = 3'd2,
    StDispense   = 3'd3,
    StDestroy    = 3'd4,
    StWaitRemove = 3'd5
  } state_e;

  // A zero timeout keeps a 1-bit timer that is never advanced.
  localparam int unsigned TmrW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TmrLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e            state_q, state_d;
  logic [TryW-1:0]   tries_q, tries_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              mismatch_q, mismatch_d;
  logic              dispense_q, dispense_d;
  logic              destroy_q, destroy_d;
  logic              wrong_q, wrong_d;
  logic [DIGIT_W-1:0] exp_digit;

  // First code digit lives in the most-significant slice.
  always_comb begin
    exp_digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (cnt_q == CntW'(i)) begin
        exp_digit = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    mismatch_d = mismatch_q;
    dispense_d = 1'b0;
    destroy_d  = 1'b0;
    wrong_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        tries_d = TryW'(MAX_TRIES);
        if (card) begin
          state_d    = StEntry;
          cnt_d      = '0;
          timer_d    = '0;
          mismatch_d = 1'b0;
        end
      end

      StEntry: begin
        if (!card) begin
          state_d    = StIdle;
          tries_d    = TryW'(MAX_TRIES);
          cnt_d      = '0;
          timer_d    = '0;
          mismatch_d = 1'b0;
        end else if (digit_valid) begin
          timer_d = '0;
          cnt_d   = cnt_q + CntW'(1);
          if (digit != exp_digit) begin
            mismatch_d = 1'b1;
          end
          if (cnt_q == CntW'(CODE_LEN - 1)) begin
            state_d = StCheck;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          timer_d = timer_q + TmrW'(1);
          if (timer_q == TmrW'(TmrLast)) begin
            state_d    = StCheck;
            mismatch_d = 1'b1;
          end
        end
      end

      StCheck: begin
        if (mismatch_q) begin
          wrong_d = 1'b1;
          if (tries_q != '0) begin
            tries_d = tries_q - TryW'(1);
          end
          // Last remaining attempt just failed: fail count has reached MAX_TRIES.
          if (tries_q <= TryW'(1)) begin
            state_d   = StDestroy;
            destroy_d = 1'b1;
          end else begin
            state_d    = StEntry;
            cnt_d      = '0;
            timer_d    = '0;
            mismatch_d = 1'b0;
          end
        end else begin
          state_d    = StDispense;
          dispense_d = 1'b1;
        end
      end

      StDispense: begin
        state_d = StWaitRemove;
      end

      StDestroy: begin
        tries_d = '0;
        state_d = StWaitRemove;
      end

      StWaitRemove: begin
        if (!card) begin
          state_d = StIdle;
          tries_d = TryW'(MAX_TRIES);
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= StIdle;
      tries_q    <= TryW'(MAX_TRIES);
      cnt_q      <= '0;
      timer_q    <= '0;
      mismatch_q <= 1'b0;
      dispense_q <= 1'b0;
      destroy_q  <= 1'b0;
      wrong_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      mismatch_q <= mismatch_d;
      dispense_q <= dispense_d;
      destroy_q  <= destroy_d;
      wrong_q    <= wrong_d;
    end
  end

  assign dispense       = dispense_q;
  assign destroy        = destroy_q;
  assign wrong          = wrong_q;
  assign tries_left     = tries_q;
  assign digits_entered = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_atm_pin_controller.sv
// Bench for atm_pin_controller: directed scenarios plus randomized sessions checked
// against a transaction-level model of attempts, outcomes and remaining tries.
module tb_atm_pin_controller;

  logic       clk;
  logic       rst, card, dv;
  logic [2:0] dg;
  logic       dispense, destroy, wrong;
  logic [1:0] tries_left, digits_entered;
  logic [2:0] state_o;

  logic       b_rst, b_card, b_dv;
  logic [3:0] b_dg;
  logic       b_dispense, b_destroy, b_wrong;
  logic [1:0] b_tries_left;
  logic [2:0] b_digits_entered;
  logic [2:0] b_state_o;

  int checks = 0;
  int failures = 0;
  int n_disp = 0, n_wrong = 0, n_destroy = 0;
  int code1[3] = '{1, 3, 7};

  atm_pin_controller dut (
    .clk_2(clk), .reset(rst), .card(card), .digit_valid(dv), .digit(dg),
    .dispense(dispense), .destroy(destroy), .wrong(wrong), .tries_left(tries_left),
    .digits_entered(digits_entered), .state_o(state_o)
  );

  atm_pin_controller #(
    .DIGIT_W(4), .CODE_LEN(4), .CODE(16'h9A05), .MAX_TRIES(2), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk_2(clk), .reset(b_rst), .card(b_card), .digit_valid(b_dv), .digit(b_dg),
    .dispense(b_dispense), .destroy(b_destroy), .wrong(b_wrong), .tries_left(b_tries_left),
    .digits_entered(b_digits_entered), .state_o(b_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dispense) n_disp <= n_disp + 1;
    if (wrong) n_wrong <= n_wrong + 1;
    if (destroy) n_destroy <= n_destroy + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Status words: {state, dispense, destroy, wrong, tries_left, digits_entered}
  function automatic logic [9:0] st1();
    return {state_o, dispense, destroy, wrong, tries_left, digits_entered};
  endfunction
  function automatic logic [9:0] e1(int s, int d, int x, int w, int t, int c);
    return {3'(s), 1'(d), 1'(x), 1'(w), 2'(t), 2'(c)};
  endfunction
  function automatic logic [10:0] st2();
    return {b_state_o, b_dispense, b_destroy, b_wrong, b_tries_left, b_digits_entered};
  endfunction
  function automatic logic [10:0] e2(int s, int d, int x, int w, int t, int c);
    return {3'(s), 1'(d), 1'(x), 1'(w), 2'(t), 3'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic send(input int d);
    dv = 1'b1; dg = 3'(d); b_dv = 1'b1; b_dg = 4'(d);
    tick();
    dv = 1'b0; b_dv = 1'b0;
  endtask
  task automatic send3(input int a, input int b, input int c);
    send(a); send(b); send(c);
  endtask

  task automatic test_reset();
    rst = 1'b1; card = 1'b0; dv = 1'b0; dg = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (st1() !== e1(0, 0, 0, 0, 3, 0)) begin
      failures++; $display("FAIL reset_state got=%h want=%h", st1(), e1(0, 0, 0, 0, 3, 0));
    end
  endtask

  task automatic test_dispense();
    card = 1'b1; tick();
    checks++;
    if (st1() !== e1(1, 0, 0, 0, 3, 0)) begin
      failures++; $display("FAIL card_in got=%h want=%h", st1(), e1(1, 0, 0, 0, 3, 0));
    end
    send3(1, 3, 7);
    checks++;
    if (st1() !== e1(2, 0, 0, 0, 3, 3)) begin
      failures++; $display("FAIL good_to_check got=%h want=%h", st1(), e1(2, 0, 0, 0, 3, 3));
    end
    tick();
    checks++;
    if (st1() !== e1(3, 1, 0, 0, 3, 3)) begin
      failures++; $display("FAIL dispense_pulse got=%h want=%h", st1(), e1(3, 1, 0, 0, 3, 3));
    end
    tick();
    checks++;
    if (st1() !== e1(5, 0, 0, 0, 3, 3)) begin
      failures++; $display("FAIL wait_remove got=%h want=%h", st1(), e1(5, 0, 0, 0, 3, 3));
    end
    // Card left in while more digits arrive: nothing may happen.
    send3(1, 3, 7); tick();
    checks++;
    if (st1() !== e1(5, 0, 0, 0, 3, 3)) begin
      failures++; $display("FAIL hold_no_redispense got=%h want=%h", st1(), e1(5, 0, 0, 0, 3, 3));
    end
    card = 1'b0; tick();
    checks++;
    if (st1() !== e1(0, 0, 0, 0, 3, 0)) begin
      failures++; $display("FAIL card_out got=%h want=%h", st1(), e1(0, 0, 0, 0, 3, 0));
    end
  endtask

  task automatic test_wrong_destroy();
    int d0;
    d0 = n_disp;
    card = 1'b1; tick();
    send3(1, 3, 6); tick();
    checks++;
    if (st1() !== e1(1, 0, 0, 1, 2, 0)) begin
      failures++; $display("FAIL wrong_1 got=%h want=%h", st1(), e1(1, 0, 0, 1, 2, 0));
    end
    send3(2, 3, 7); tick();
    checks++;
    if (st1() !== e1(1, 0, 0, 1, 1, 0)) begin
      failures++; $display("FAIL wrong_2 got=%h want=%h", st1(), e1(1, 0, 0, 1, 1, 0));
    end
    send3(0, 0, 0); tick();
    checks++;
    if (st1() !== e1(4, 0, 1, 1, 0, 3)) begin
      failures++; $display("FAIL destroy_pulse got=%h want=%h", st1(), e1(4, 0, 1, 1, 0, 3));
    end
    tick();
    checks++;
    if (st1() !== e1(5, 0, 0, 0, 0, 3)) begin
      failures++; $display("FAIL after_destroy got=%h want=%h", st1(), e1(5, 0, 0, 0, 0, 3));
    end
    card = 1'b0; tick(); tick();
    checks++;
    if (n_disp !== d0) begin
      failures++; $display("FAIL destroy_no_dispense got=%0d want=%0d", n_disp, d0);
    end
  endtask

  task automatic test_timeout();
    card = 1'b1; tick();
    send(1);
    idle(15);
    checks++;
    if (st1() !== e1(1, 0, 0, 0, 3, 1)) begin
      failures++; $display("FAIL timeout_not_yet got=%h want=%h", st1(), e1(1, 0, 0, 0, 3, 1));
    end
    tick();
    checks++;
    if (st1() !== e1(2, 0, 0, 0, 3, 1)) begin
      failures++; $display("FAIL timeout_check got=%h want=%h", st1(), e1(2, 0, 0, 0, 3, 1));
    end
    tick();
    checks++;
    if (st1() !== e1(1, 0, 0, 1, 2, 0)) begin
      failures++; $display("FAIL timeout_wrong got=%h want=%h", st1(), e1(1, 0, 0, 1, 2, 0));
    end
    send3(1, 3, 7); tick();
    checks++;
    if (st1() !== e1(3, 1, 0, 0, 2, 3)) begin
      failures++; $display("FAIL timeout_then_ok got=%h want=%h", st1(), e1(3, 1, 0, 0, 2, 3));
    end
    card = 1'b0; tick(); tick();
  endtask

  task automatic test_abort();
    card = 1'b1; tick();
    send3(1, 3, 6); tick();
    send3(1, 3, 6); tick();
    checks++;
    if (tries_left !== 2'd1) begin
      failures++; $display("FAIL abort_pre_tries got=%0d want=1", tries_left);
    end
    send(1);
    card = 1'b0; tick();
    checks++;
    if (st1() !== e1(0, 0, 0, 0, 3, 0)) begin
      failures++; $display("FAIL abort_idle got=%h want=%h", st1(), e1(0, 0, 0, 0, 3, 0));
    end
    card = 1'b1; tick();
    send3(1, 3, 7); tick();
    checks++;
    if (st1() !== e1(3, 1, 0, 0, 3, 3)) begin
      failures++; $display("FAIL abort_reinsert_ok got=%h want=%h", st1(), e1(3, 1, 0, 0, 3, 3));
    end
    card = 1'b0; tick(); tick();
  endtask

  task automatic test_reset_mid();
    card = 1'b1; tick();
    send(1); send(3);
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if (st1() !== e1(0, 0, 0, 0, 3, 0)) begin
      failures++; $display("FAIL reset_mid got=%h want=%h", st1(), e1(0, 0, 0, 0, 3, 0));
    end
    tick();
    checks++;
    if (st1() !== e1(1, 0, 0, 0, 3, 0)) begin
      failures++; $display("FAIL reset_mid_reenter got=%h want=%h", st1(), e1(1, 0, 0, 0, 3, 0));
    end
    card = 1'b0; tick(); tick();
  endtask

  // Model: an attempt succeeds iff every digit equals the code digit and no idle run hits
  // the timeout; each failure costs one try; the third failure destroys the card.
  task automatic test_random();
    int tries_m, exp_disp, exp_wrong, exp_destroy, d0, w0, x0, kind, k, ecnt;
    int d[3];
    bit bad, done;
    for (int s = 0; s < 10; s++) begin
      d0 = n_disp; w0 = n_wrong; x0 = n_destroy;
      exp_disp = 0; exp_wrong = 0; exp_destroy = 0;
      tries_m = 3; done = 0;
      card = 1'b1; tick();
      while (!done) begin
        kind = int'($urandom_range(0, 2));
        bad = 0; ecnt = 3;
        if (kind == 2) begin
          k = int'($urandom_range(0, 2));
          for (int j = 0; j < k; j++) begin
            idle(int'($urandom_range(0, 3)));
            send(int'($urandom_range(0, 7)));
          end
          idle(16);
          bad = 1; ecnt = k;
        end else begin
          for (int j = 0; j < 3; j++) begin
            d[j] = (kind == 0) ? code1[j] : int'($urandom_range(0, 7));
            if (d[j] != code1[j]) bad = 1;
            idle(int'($urandom_range(0, 3)));
            send(d[j]);
          end
        end
        tick();
        if (!bad) begin
          exp_disp++; done = 1;
          checks++;
          if (st1() !== e1(3, 1, 0, 0, tries_m, 3)) begin
            failures++;
            $display("FAIL rand_dispense s=%0d got=%h want=%h", s, st1(), e1(3, 1, 0, 0, tries_m, 3));
          end
        end else begin
          tries_m--; exp_wrong++;
          if (tries_m == 0) begin
            exp_destroy++; done = 1;
            checks++;
            if (st1() !== e1(4, 0, 1, 1, 0, ecnt)) begin
              failures++;
              $display("FAIL rand_destroy s=%0d got=%h want=%h", s, st1(), e1(4, 0, 1, 1, 0, ecnt));
            end
          end else begin
            checks++;
            if (st1() !== e1(1, 0, 0, 1, tries_m, 0)) begin
              failures++;
              $display("FAIL rand_wrong s=%0d got=%h want=%h", s, st1(), e1(1, 0, 0, 1, tries_m, 0));
            end
          end
        end
      end
      tick();
      for (int j = int'($urandom_range(0, 4)); j > 0; j--) send(int'($urandom_range(0, 7)));
      checks++;
      if (state_o !== 3'd5) begin
        failures++; $display("FAIL rand_wait_remove s=%0d got=%0d want=5", s, state_o);
      end
      card = 1'b0; tick(); tick();
      checks++;
      if ((n_disp - d0) !== exp_disp || (n_wrong - w0) !== exp_wrong ||
          (n_destroy - x0) !== exp_destroy) begin
        failures++;
        $display("FAIL rand_pulse_counts s=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", s,
                 n_disp - d0, n_wrong - w0, n_destroy - x0, exp_disp, exp_wrong, exp_destroy);
      end
    end
  endtask

  task automatic test_param_set();
    b_rst = 1'b1; b_card = 1'b0; b_dv = 1'b0; b_dg = '0;
    tick(); b_rst = 1'b0;
    checks++;
    if (st2() !== e2(0, 0, 0, 0, 2, 0)) begin
      failures++; $display("FAIL p2_reset got=%h want=%h", st2(), e2(0, 0, 0, 0, 2, 0));
    end
    b_card = 1'b1; tick();
    send(9); send(10); send(0); send(5);
    checks++;
    if (st2() !== e2(2, 0, 0, 0, 2, 4)) begin
      failures++; $display("FAIL p2_check got=%h want=%h", st2(), e2(2, 0, 0, 0, 2, 4));
    end
    tick();
    checks++;
    if (st2() !== e2(3, 1, 0, 0, 2, 4)) begin
      failures++; $display("FAIL p2_dispense got=%h want=%h", st2(), e2(3, 1, 0, 0, 2, 4));
    end
    b_card = 1'b0; tick(); tick();
    b_card = 1'b1; tick();
    send(9); send(10); send(0); send(4); tick();
    checks++;
    if (st2() !== e2(1, 0, 0, 1, 1, 0)) begin
      failures++; $display("FAIL p2_wrong got=%h want=%h", st2(), e2(1, 0, 0, 1, 1, 0));
    end
    send(0); send(0); send(0); send(0); tick();
    checks++;
    if (st2() !== e2(4, 0, 1, 1, 0, 4)) begin
      failures++; $display("FAIL p2_destroy got=%h want=%h", st2(), e2(4, 0, 1, 1, 0, 4));
    end
    b_card = 1'b0; tick(); tick();
    b_card = 1'b1; tick();
    idle(100);
    send(9);
    idle(60);
    checks++;
    if (st2() !== e2(1, 0, 0, 0, 2, 1)) begin
      failures++; $display("FAIL p2_no_timeout got=%h want=%h", st2(), e2(1, 0, 0, 0, 2, 1));
    end
    send(10); send(0); send(5); tick();
    checks++;
    if (st2() !== e2(3, 1, 0, 0, 2, 4)) begin
      failures++; $display("FAIL p2_late_dispense got=%h want=%h", st2(), e2(3, 1, 0, 0, 2, 4));
    end
    b_card = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; card = 1'b0; dv = 1'b0; dg = '0;
    b_rst = 1'b1; b_card = 1'b0; b_dv = 1'b0; b_dg = '0;
    test_reset();
    test_dispense();
    test_wrong_destroy();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    test_param_set();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
